// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - Shared pixel, window and gradient types for the Sobel edge stage
package sobel_pkg;

  typedef logic [7:0]         pixel_t;
  typedef pixel_t [0:8]       window_t;
  typedef logic signed [10:0] grad_t;
  typedef logic [10:0]        mag_t;

  localparam pixel_t PIX_MAX = 8'd255;

  // Window index = col*3 + row; col 0 is the left column, row 0 the top row.
  localparam int TL = 0;
  localparam int ML = 1;
  localparam int BL = 2;
  localparam int TC = 3;
  localparam int MC = 4;
  localparam int BC = 5;
  localparam int TR = 6;
  localparam int MR = 7;
  localparam int BR = 8;

  function automatic grad_t px_ext(pixel_t p);
    return grad_t'({3'b000, p});
  endfunction

endpackage

// File: rtl/sobel_kernel.sv
// rtl/sobel_kernel.sv - Combinational 3x3 Sobel operator producing signed Gx and Gy
module sobel_kernel
  import sobel_pkg::*;
(
  input  window_t window_i,
  output grad_t   gx_o,
  output grad_t   gy_o
);

  // Gx: right column minus left column; Gy: bottom row minus top row.
  // Both sides peak at 1020, so 11-bit signed arithmetic never overflows.
  assign gx_o = (px_ext(window_i[TR]) + (px_ext(window_i[MR]) <<< 1) + px_ext(window_i[BR]))
              - (px_ext(window_i[TL]) + (px_ext(window_i[ML]) <<< 1) + px_ext(window_i[BL]));

  assign gy_o = (px_ext(window_i[BL]) + (px_ext(window_i[BC]) <<< 1) + px_ext(window_i[BR]))
              - (px_ext(window_i[TL]) + (px_ext(window_i[TC]) <<< 1) + px_ext(window_i[TR]));

endmodule

// File: rtl/sobel_gradient.sv
// rtl/sobel_gradient.sv - 3-stage Sobel magnitude pipeline with backpressure and frame counter; SOBEL_THRESH_EN selects binarised output
module sobel_gradient
  import sobel_pkg::*;
#(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
`ifdef SOBEL_THRESH_EN
  ,
  parameter int THRESHOLD = 128
`endif
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  window_t                          window_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output pixel_t                           edge_out,
  output logic [$clog2(IMG_W*IMG_H)-1:0]   pixel_count,
  output logic                             frame_done
);

  localparam int FRAME_LEN = IMG_W * IMG_H;
  localparam int CNT_W     = $clog2(FRAME_LEN);

  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_LAST = cnt_t'(FRAME_LEN - 1);

  grad_t  gx_c, gy_c;
  grad_t  gx_q, gy_q;
  mag_t   mag_q, mag_d;
  pixel_t edge_q, edge_d;
  cnt_t   cnt_q, cnt_d;
  logic   s1_valid_q, s2_valid_q, s3_valid_q;
  logic   advance, out_hs, last_pix;

  sobel_kernel u_kernel (
    .window_i (window_in),
    .gx_o     (gx_c),
    .gy_o     (gy_c)
  );

  function automatic mag_t abs_grad(grad_t g);
    return g[10] ? mag_t'(-g) : mag_t'(g);
  endfunction

  always_comb begin
    advance  = !s3_valid_q || out_ready;
    out_hs   = s3_valid_q && out_ready;
    last_pix = (cnt_q == CNT_LAST);
    mag_d    = abs_grad(gx_q) + abs_grad(gy_q);
`ifdef SOBEL_THRESH_EN
    edge_d   = (mag_q >= mag_t'(THRESHOLD)) ? 8'hFF : 8'h00;
`else
    edge_d   = (mag_q > mag_t'(PIX_MAX)) ? PIX_MAX : mag_q[7:0];
`endif
    cnt_d    = cnt_q;
    if (out_hs) begin
      cnt_d = last_pix ? '0 : cnt_q + 1'b1;
    end
  end

  // All stages move together; bubbles travel with the data rather than collapsing.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      gx_q       <= '0;
      gy_q       <= '0;
      mag_q      <= '0;
      edge_q     <= '0;
    end else if (advance) begin
      s1_valid_q <= in_valid;
      s2_valid_q <= s1_valid_q;
      s3_valid_q <= s2_valid_q;
      if (in_valid) begin
        gx_q <= gx_c;
        gy_q <= gy_c;
      end
      mag_q  <= mag_d;
      edge_q <= edge_d;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign in_ready    = advance;
  assign out_valid   = s3_valid_q;
  assign edge_out    = edge_q;
  assign pixel_count = cnt_q;
  assign frame_done  = out_hs && last_pix;

endmodule

// File: tb/tb_sobel_gradient.sv
// tb/tb_sobel_gradient.sv - Directed self-checking bench for sobel_gradient
module tb_sobel_gradient;
  import sobel_pkg::*;

  localparam int IMG_W = 4;
  localparam int IMG_H = 2;
  localparam int FRAME = IMG_W * IMG_H;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  window_t    window_in = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  pixel_t     edge_out;
  logic [2:0] pixel_count;
  logic       frame_done;

  int      vectors = 0;
  int      miscompares = 0;
  window_t win_tab[8];
  int      mag_tab[8];

  always #5 clk = ~clk;

  sobel_gradient #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .window_in   (window_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .edge_out    (edge_out),
    .pixel_count (pixel_count),
    .frame_done  (frame_done)
  );

  function automatic logic [7:0] exp_edge(input int mag);
`ifdef SOBEL_THRESH_EN
    return (mag >= 128) ? 8'hFF : 8'h00;
`else
    return (mag > 255) ? 8'd255 : 8'(mag);
`endif
  endfunction

  function automatic window_t one_px(input int idx, input pixel_t v);
    window_t w;
    w = '0;
    w[idx] = v;
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  // Single isolated window: output must rise on the third edge counting the accepting one.
  task automatic send_one(input string tag, input window_t w, input int mag);
    @(negedge clk);
    window_in = w;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1 check({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    window_in = '0;
    check({tag, "_lat1"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_lat2"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_edge"}, edge_out, exp_edge(mag));
    @(negedge clk);
    check({tag, "_bubble"}, out_valid, 0);
  endtask

  task automatic run_stream(input string tag, input int n, input int stall);
    int sent = 0;
    int got = 0;
    int stall_left = stall;
    bit seen = 1'b0;
    for (int cyc = 0; cyc < 80 && got < n; cyc++) begin
      @(negedge clk);
      if (out_valid && !seen) seen = 1'b1;
      out_ready = !(seen && stall_left > 0);
      in_valid = (sent < n);
      window_in = (sent < n) ? win_tab[sent] : '0;
      #1;
      if (!out_ready) begin
        check({tag, "_stall_in_ready"}, in_ready, 0);
        check({tag, "_stall_valid"}, out_valid, 1);
        check({tag, "_stall_edge"}, edge_out, exp_edge(mag_tab[got]));
        stall_left--;
      end
      if (out_valid && out_ready) begin
        check({tag, "_edge"}, edge_out, exp_edge(mag_tab[got]));
        check({tag, "_count"}, pixel_count, got % FRAME);
        check({tag, "_frame_done"}, frame_done, (got % FRAME) == FRAME - 1);
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    window_in = '0;
    out_ready = 1'b1;
    check({tag, "_outputs"}, got, n);
    @(negedge clk);
    check({tag, "_drained"}, out_valid, 0);
  endtask

  initial begin
    window_t vert;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_edge_out", edge_out, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_pixel_count", pixel_count, 0);
    check("rst_frame_done", frame_done, 0);
    n_rst = 1'b1;

    // Isolated windows
    for (int i = 0; i < 9; i++) vert[i] = (i < 3) ? 8'd0 : (i < 6) ? 8'd50 : 8'd255;
    send_one("uniform", {9{8'd100}}, 0);
    send_one("vertical", vert, 1020);
    send_one("br10", one_px(BR, 8'd10), 20);
    send_one("tl10", one_px(TL, 8'd10), 20);
    send_one("mc200", one_px(MC, 8'd200), 0);
    send_one("tc40", one_px(TC, 8'd40), 80);
    check("single_count", pixel_count, 6);

    // Backpressure: 5 windows, 4-cycle stall after first out_valid
    do_reset();
    for (int k = 0; k < 5; k++) begin
      win_tab[k] = one_px(BR, pixel_t'(10 * (k + 1)));
      mag_tab[k] = 20 * (k + 1);
    end
    run_stream("bp", 5, 4);
    check("bp_count", pixel_count, 5);

    // Full frame of 8 outputs
    do_reset();
    for (int k = 0; k < 8; k++) begin
      win_tab[k] = one_px(MR, pixel_t'(8 * (k + 1)));
      mag_tab[k] = 16 * (k + 1);
    end
    run_stream("frame", 8, 0);
    check("frame_count_wrap", pixel_count, 0);
    check("frame_done_after", frame_done, 0);

    // Asynchronous reset with three windows in flight
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      window_in = one_px(BR, pixel_t'(10 * (k + 1)));
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    window_in = '0;
    check("arst_pre_count", pixel_count, 1);
    check("arst_pre_valid", out_valid, 1);
    #2 n_rst = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_pixel_count", pixel_count, 0);
    check("arst_frame_done", frame_done, 0);
    check("arst_in_ready", in_ready, 1);
    @(negedge clk);
    check("arst_held_valid", out_valid, 0);
    n_rst = 1'b1;
    send_one("post_rst", vert, 1020);
    check("post_rst_count", pixel_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
